// File: rtl/apb_periph_node.sv
// APB peripheral node: one upstream APB slave port fanned out to NB_PORTS APB masters.
// Address decode over enabled ranges, timeout supervision and sticky error reporting.
module apb_periph_node #(
  parameter int unsigned NB_PORTS       = 12,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  // upstream slave side
  input  logic [APB_ADDR_WIDTH-1:0]                    paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]                    pwdata_i,
  input  logic                                         pwrite_i,
  input  logic                                         psel_i,
  input  logic                                         penable_i,
  output logic [APB_DATA_WIDTH-1:0]                    prdata_o,
  output logic                                         pready_o,
  output logic                                         pslverr_o,
  // downstream master side
  output logic [NB_PORTS-1:0][APB_ADDR_WIDTH-1:0]      paddr_o,
  output logic [NB_PORTS-1:0][APB_DATA_WIDTH-1:0]      pwdata_o,
  output logic [NB_PORTS-1:0]                          pwrite_o,
  output logic [NB_PORTS-1:0]                          psel_o,
  output logic [NB_PORTS-1:0]                          penable_o,
  input  logic [NB_PORTS-1:0][APB_DATA_WIDTH-1:0]      prdata_i,
  input  logic [NB_PORTS-1:0]                          pready_i,
  input  logic [NB_PORTS-1:0]                          pslverr_i,
  // address map
  input  logic [NB_PORTS-1:0][APB_ADDR_WIDTH-1:0]      start_addr_i,
  input  logic [NB_PORTS-1:0][APB_ADDR_WIDTH-1:0]      end_addr_i,
  input  logic [NB_PORTS-1:0]                          port_en_i,
  // error reporting
  output logic                                         err_o,
  output logic [APB_ADDR_WIDTH-1:0]                    err_addr_o,
  output logic                                         err_timeout_o
);

  localparam int unsigned IDX_W    = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned CNT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_RESP   = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [APB_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [APB_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                        write_q, write_d;
  logic [NB_PORTS-1:0]         psel_q, psel_d;
  logic [NB_PORTS-1:0]         penable_q, penable_d;
  logic [APB_DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                        pready_q, pready_d;
  logic                        pslverr_q, pslverr_d;
  logic                        err_q, err_d;
  logic [APB_ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
  logic                        err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        abandon_q, abandon_d;

  logic                        hit_c;
  logic [IDX_W-1:0]            hit_idx_c;
  logic                        sel_ready_c;
  logic                        sel_err_c;
  logic [APB_DATA_WIDTH-1:0]   sel_rdata_c;
  logic                        timeout_c;
  logic                        abandon_c;
  logic [CNT_W-1:0]            cnt_inc_c;

  // Priority decode: descending scan so the lowest matching enabled port wins.
  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int i = NB_PORTS - 1; i >= 0; i--) begin
      if (port_en_i[i] && (start_addr_i[i] <= paddr_i) && (paddr_i <= end_addr_i[i])) begin
        hit_c     = 1'b1;
        hit_idx_c = IDX_W'(i);
      end
    end
  end

  assign sel_ready_c = pready_i[idx_q];
  assign sel_err_c   = pslverr_i[idx_q];
  assign sel_rdata_c = prdata_i[idx_q];
  assign timeout_c   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(CNT_LAST));
  assign abandon_c   = abandon_q | ~psel_i;
  assign cnt_inc_c   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    write_d       = write_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    prdata_d      = '0;
    pready_d      = 1'b0;
    pslverr_d     = 1'b0;
    err_d         = 1'b0;
    err_addr_d    = err_addr_q;
    err_timeout_d = err_timeout_q;
    cnt_d         = cnt_q;
    abandon_d     = abandon_q | ~psel_i;

    unique case (state_q)
      S_IDLE: begin
        abandon_d = 1'b0;
        psel_d    = '0;
        penable_d = '0;
        if (psel_i && !penable_i) begin
          addr_d  = paddr_i;
          wdata_d = pwdata_i;
          write_d = pwrite_i;
          if (hit_c) begin
            idx_d           = hit_idx_c;
            psel_d          = '0;
            psel_d[hit_idx_c] = 1'b1;
            state_d         = S_SETUP;
          end else begin
            pready_d      = 1'b1;
            pslverr_d     = 1'b1;
            err_d         = 1'b1;
            err_addr_d    = paddr_i;
            err_timeout_d = 1'b0;
            state_d       = S_ERR;
          end
        end
      end

      S_SETUP: begin
        penable_d = psel_q;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end

      S_ACCESS: begin
        if (sel_ready_c) begin
          psel_d    = '0;
          penable_d = '0;
          pready_d  = ~abandon_c;
          pslverr_d = sel_err_c & ~abandon_c;
          prdata_d  = abandon_c ? '0 : sel_rdata_c;
          state_d   = S_RESP;
        end else if (timeout_c) begin
          // Timeout reuses the ERR response cycle, flagged as a timeout.
          psel_d        = '0;
          penable_d     = '0;
          cnt_d         = cnt_inc_c;
          pready_d      = ~abandon_c;
          pslverr_d     = ~abandon_c;
          err_d         = 1'b1;
          err_addr_d    = addr_q;
          err_timeout_d = 1'b1;
          state_d       = S_ERR;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      psel_q        <= '0;
      penable_q     <= '0;
      prdata_q      <= '0;
      pready_q      <= 1'b0;
      pslverr_q     <= 1'b0;
      err_q         <= 1'b0;
      err_addr_q    <= '0;
      err_timeout_q <= 1'b0;
      cnt_q         <= '0;
      abandon_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      write_q       <= write_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      prdata_q      <= prdata_d;
      pready_q      <= pready_d;
      pslverr_q     <= pslverr_d;
      err_q         <= err_d;
      err_addr_q    <= err_addr_d;
      err_timeout_q <= err_timeout_d;
      cnt_q         <= cnt_d;
      abandon_q     <= abandon_d;
    end
  end

  // Address/data/write are broadcast to every port; only psel qualifies them.
  always_comb begin
    for (int i = 0; i < NB_PORTS; i++) begin
      paddr_o[i]  = addr_q;
      pwdata_o[i] = wdata_q;
      pwrite_o[i] = write_q;
    end
  end

  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign prdata_o      = prdata_q;
  assign pready_o      = pready_q;
  assign pslverr_o     = pslverr_q;
  assign err_o         = err_q;
  assign err_addr_o    = err_addr_q;
  assign err_timeout_o = err_timeout_q;

endmodule

// File: tb/tb_apb_periph_node.sv
// Self-checking bench for apb_periph_node: directed scenarios plus randomized
// transfers against a latency/decode/memory reference model.
module tb_apb_periph_node;

  localparam int NP = 12;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [AW-1:0]          paddr_i;
  logic [DW-1:0]          pwdata_i;
  logic                   pwrite_i, psel_i, penable_i;
  logic [DW-1:0]          prdata_o;
  logic                   pready_o, pslverr_o;
  logic [NP-1:0][AW-1:0]  paddr_o;
  logic [NP-1:0][DW-1:0]  pwdata_o;
  logic [NP-1:0]          pwrite_o, psel_o, penable_o;
  logic [NP-1:0][DW-1:0]  prdata_i;
  logic [NP-1:0]          pready_i, pslverr_i;
  logic [NP-1:0][AW-1:0]  start_addr_i, end_addr_i;
  logic [NP-1:0]          port_en_i;
  logic                   err_o, err_timeout_o;
  logic [AW-1:0]          err_addr_o;

  apb_periph_node #(
    .NB_PORTS(NP), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pwrite_i(pwrite_i),
    .psel_i(psel_i), .penable_i(penable_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o),
    .psel_o(psel_o), .penable_o(penable_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .start_addr_i(start_addr_i), .end_addr_i(end_addr_i), .port_en_i(port_en_i),
    .err_o(err_o), .err_addr_o(err_addr_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Downstream slave environment: programmable wait states, error flag, 16-word memory.
  int          slave_wait [NP];
  logic        slave_err  [NP];
  int          acc        [NP];
  logic [31:0] slv_mem    [NP][16];
  logic        pl_req;
  int          pl_port;
  int          pl_idx;
  logic [31:0] pl_data;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      pready_i[p]  = psel_o[p] & penable_o[p] & (acc[p] == slave_wait[p]);
      prdata_i[p]  = slv_mem[p][paddr_o[p][5:2]];
      pslverr_i[p] = slave_err[p];
    end
  end

  always @(posedge clk_i) begin
    for (int p = 0; p < NP; p++) begin
      if (rst_i || !(psel_o[p] && penable_o[p]) || pready_i[p]) acc[p] <= 0;
      else acc[p] <= acc[p] + 1;
      if (rst_i) begin
        for (int w = 0; w < 16; w++) slv_mem[p][w] <= '0;
      end else if (psel_o[p] && penable_o[p] && pready_i[p] && pwrite_o[p]) begin
        slv_mem[p][paddr_o[p][5:2]] <= pwdata_o[p];
      end
    end
    if (pl_req && !rst_i) slv_mem[pl_port][pl_idx] <= pl_data;
  end

  // Reference model state.
  logic [31:0] exp_mem [NP][16];
  logic [31:0] m_err_addr;
  logic        m_err_to;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1;
    repeat (n) step();
    rst_i = 1'b0;
    m_err_addr = '0;
    m_err_to   = 1'b0;
    for (int p = 0; p < NP; p++)
      for (int w = 0; w < 16; w++) exp_mem[p][w] = '0;
  endtask

  task automatic preload(input int p, input int idx, input logic [31:0] d);
    pl_req = 1'b1; pl_port = p; pl_idx = idx; pl_data = d;
    step();
    pl_req = 1'b0;
    exp_mem[p][idx] = d;
  endtask

  function automatic int exp_target(input logic [31:0] a);
    for (int p = 0; p < NP; p++)
      if (port_en_i[p] && start_addr_i[p] <= a && a <= end_addr_i[p]) return p;
    return -1;
  endfunction

  task automatic cfg_default();
    for (int p = 0; p < NP; p++) begin
      start_addr_i[p] = 32'h1000_0000 + 32'(p) * 32'h1000;
      end_addr_i[p]   = start_addr_i[p] + 32'h0FFF;
      slave_wait[p]   = 0;
      slave_err[p]    = 1'b0;
    end
    start_addr_i[9] = 32'h1000_2000;
    end_addr_i[9]   = 32'h1000_5FFF;
    port_en_i = '1;
  endtask

  // One upstream transfer, checked against the model computed at capture time.
  task automatic xfer(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic wr, input bit toggle_en);
    int t, lat, k;
    bit e_err, e_to, got;
    logic e_slv;
    logic [31:0] e_rd;
    logic [NP-1:0] e_sel, saved_en;
    t = exp_target(addr);
    e_sel = (t >= 0) ? (NP'(1) << t) : '0;
    e_to = 1'b0;
    if (t < 0) begin
      lat = 1; e_err = 1'b1; e_slv = 1'b1; e_rd = '0;
    end else if (slave_wait[t] <= TO - 1) begin
      lat = 3 + slave_wait[t]; e_err = 1'b0; e_slv = slave_err[t]; e_rd = exp_mem[t][addr[5:2]];
    end else begin
      lat = 2 + TO; e_err = 1'b1; e_to = 1'b1; e_slv = 1'b1; e_rd = '0;
    end
    if (e_err) begin m_err_addr = addr; m_err_to = e_to; end

    saved_en = port_en_i;
    paddr_i = addr; pwdata_i = wdata; pwrite_i = wr; psel_i = 1'b1; penable_i = 1'b0;
    k = 0; got = 1'b0;
    while (!got && k < 20) begin
      step(); k++;
      if (k == 1) begin
        penable_i = 1'b1;
        chk({tag, "_psel_t1"}, 64'(psel_o), 64'(e_sel));
        chk({tag, "_pen_t1"}, 64'(penable_o), 64'd0);
        if (toggle_en) port_en_i = ~port_en_i;
      end
      if (k == 2 && t >= 0) chk({tag, "_pen_t2"}, 64'(penable_o), 64'(e_sel));
      if (pready_o) got = 1'b1;
    end
    chk({tag, "_latency"}, 64'(k), 64'(lat));
    chk({tag, "_pslverr"}, 64'(pslverr_o), 64'(e_slv));
    chk({tag, "_err"}, 64'(err_o), 64'(e_err));
    chk({tag, "_erraddr"}, 64'(err_addr_o), 64'(m_err_addr));
    chk({tag, "_errto"}, 64'(err_timeout_o), 64'(m_err_to));
    chk({tag, "_psel_resp"}, 64'(psel_o), 64'd0);
    if (!wr || e_err) chk({tag, "_rdata"}, 64'(prdata_o), 64'(e_rd));
    psel_i = 1'b0; penable_i = 1'b0;
    port_en_i = saved_en;
    step();
    chk({tag, "_pready_1cyc"}, 64'(pready_o), 64'd0);
    chk({tag, "_err_1cyc"}, 64'(err_o), 64'd0);
    if (wr && !e_err) exp_mem[t][addr[5:2]] = wdata;
  endtask

  initial begin
    logic [31:0] a;
    int r;
    rst_i = 1'b1; paddr_i = '0; pwdata_i = '0; pwrite_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
    pl_req = 1'b0; pl_port = 0; pl_idx = 0; pl_data = '0;
    cfg_default();
    do_reset(3);

    chk("rst_psel", 64'(psel_o), 64'd0);
    chk("rst_pready", 64'(pready_o), 64'd0);
    chk("rst_prdata", 64'(prdata_o), 64'd0);
    chk("rst_erraddr", 64'(err_addr_o), 64'd0);
    chk("rst_paddr0", 64'(paddr_o[0]), 64'd0);

    // Protocol violation in IDLE: psel with penable is not captured.
    paddr_i = 32'h1000_0000; psel_i = 1'b1; penable_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("viol_psel", 64'(psel_o), 64'd0);
      chk("viol_pready", 64'(pready_o), 64'd0);
    end
    psel_i = 1'b0; penable_i = 1'b0; step();

    // Directed map for named scenarios.
    start_addr_i[1] = 32'h1A10_0000; end_addr_i[1] = 32'h1A10_0FFF;
    start_addr_i[2] = 32'h1A11_0000; end_addr_i[2] = 32'h1A11_0FFF;
    start_addr_i[3] = 32'h1A30_0000; end_addr_i[3] = 32'h1A30_0FFF;
    start_addr_i[5] = 32'h1A30_0000; end_addr_i[5] = 32'h1A30_1FFF;
    port_en_i[3] = 1'b0;

    xfer("wr_p1", 32'h1A10_0004, 32'h1234_5678, 1'b1, 1'b0);
    xfer("rd_p1", 32'h1A10_0004, 32'h0, 1'b0, 1'b0);

    preload(2, 2, 32'hDEAD_BEEF);
    slave_wait[2] = 3;
    xfer("rd_p2_wait3", 32'h1A11_0008, 32'h0, 1'b0, 1'b0);

    xfer("decode_miss", 32'h1A20_0000, 32'h5555_5555, 1'b1, 1'b0);

    slave_wait[1] = 50;
    xfer("timeout", 32'h1A10_0010, 32'h0, 1'b0, 1'b0);
    slave_wait[1] = 3;
    xfer("ready_at_limit", 32'h1A10_0004, 32'h0, 1'b0, 1'b0);

    slave_wait[5] = 1;
    xfer("overlap_p5", 32'h1A30_0040, 32'hA5A5_0001, 1'b1, 1'b1);
    xfer("overlap_p5_rd", 32'h1A30_0040, 32'h0, 1'b0, 1'b0);

    // Reset asserted while the downstream access is stalled.
    slave_wait[1] = 50;
    paddr_i = 32'h1A10_0000; pwdata_i = 32'hFFFF_FFFF; pwrite_i = 1'b1; psel_i = 1'b1; penable_i = 1'b0;
    step(); penable_i = 1'b1;
    step(); step();
    rst_i = 1'b1; step(); rst_i = 1'b0;
    psel_i = 1'b0; penable_i = 1'b0;
    chk("rstmid_psel", 64'(psel_o), 64'd0);
    chk("rstmid_pen", 64'(penable_o), 64'd0);
    chk("rstmid_pready", 64'(pready_o), 64'd0);
    chk("rstmid_err", 64'(err_o), 64'd0);
    chk("rstmid_paddr1", 64'(paddr_o[1]), 64'd0);
    chk("rstmid_pwdata1", 64'(pwdata_o[1]), 64'd0);
    chk("rstmid_pwrite", 64'(pwrite_o), 64'd0);
    chk("rstmid_erraddr", 64'(err_addr_o), 64'd0);
    m_err_addr = '0; m_err_to = 1'b0;
    for (int p = 0; p < NP; p++)
      for (int w = 0; w < 16; w++) exp_mem[p][w] = '0;
    slave_wait[1] = 0;
    xfer("post_rst_wr", 32'h1A10_0020, 32'hCAFE_0001, 1'b1, 1'b0);
    xfer("post_rst_rd", 32'h1A10_0020, 32'h0, 1'b0, 1'b0);

    // Randomized traffic over the default map, including unmapped windows and range ends.
    cfg_default();
    for (int n = 0; n < 80; n++) begin
      for (int p = 0; p < NP; p++) begin
        slave_wait[p] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 2));
        slave_err[p]  = ($urandom_range(0, 7) == 0);
      end
      port_en_i = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '1;
      r = int'($urandom_range(0, 13));
      a = 32'h1000_0000 + 32'(r) * 32'h1000;
      a = a + (($urandom_range(0, 3) == 0) ? 32'h0FFC : 32'($urandom_range(0, 15)) << 2);
      xfer("rand", a, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
